audio_dac_scheduler: RTL and testbench
======================================

Name: audio_dac_scheduler

Overview:
- Sequences the 32-bit audio DAC serializer. Shares it between two sample sources, such as a tone generator and a playback buffer.
- Presents one stable sample word per frame on the serializer's parallel input. Fetches the next word when the serializer reports done.
- Inserts silence or a repeat on underrun and flags a stalled serializer.
- Sits between the sample producers and the DAC serializer, in the AUD_BCLK domain.

Parameters:
- DATA_W, 32: sample word width; must match the serializer input.
- TIMEOUT_CYCLES, 256: clocks allowed in WAIT_DONE before timeout_err sets.
- UNDERRUN_HOLD, 0: on underrun, 0 = output zero, 1 = repeat the last sample.

Ports:
- AUD_BCLK  in  1  audio bit clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run; 0 = go idle at the next frame boundary.
- rr_mode  in  1  0 = fixed priority (src0 wins); 1 = round robin.
- src0_valid  in  1  source 0 has a sample.
- src0_data  in  DATA_W  source 0 sample.
- src0_ready  out  1  one-cycle accept pulse to source 0.
- src1_valid  in  1  source 1 has a sample.
- src1_data  in  DATA_W  source 1 sample.
- src1_ready  out  1  one-cycle accept pulse to source 1.
- dac_done  in  1  serializer done flag.
- dac_sample  out  DATA_W  word driven to the serializer's parallel input.
- grant  out  2  one-hot owner of the current frame; 00 = none.
- busy  out  1  high in FETCH and WAIT_DONE.
- underrun_cnt  out  16  saturating count of frames with no valid source.
- timeout_err  out  1  sticky stall flag; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous), all registers cleared:
  - state=IDLE; dac_sample=0; src0_ready=src1_ready=0; grant=00; busy=0.
  - underrun_cnt=0; timeout_err=0; last_grant=src1, so the first RR grant goes to src0; done_q=0; timeout counter=0.
- done_rise = dac_done & ~done_q, where done_q is dac_done registered. A level-held done therefore counts once.
- IDLE:
  - dac_sample=0, grant=00.
  - enable=1 -> FETCH on the next edge.
- FETCH (exactly one cycle):
  - Selection with both valid:
    - rr_mode=0: src0.
    - rr_mode=1: the source that is not last_grant.
  - Selection with one valid: that source.
  - Source selected:
    - dac_sample <= data; grant <= one-hot.
    - The matching srcN_ready is high during this cycle (combinational from state and selection), so the transfer completes at this edge.
    - last_grant updates.
  - No source valid (underrun):
    - dac_sample <= 0 if UNDERRUN_HOLD=0, otherwise unchanged.
    - grant <= 00; underrun_cnt += 1, saturating at 16'hFFFF.
  - -> WAIT_DONE in all cases.
- WAIT_DONE:
  - dac_sample is held constant for the whole state. The serializer samples its input while waiting for LRCK.
  - The timeout counter increments each cycle.
  - done_rise & enable -> FETCH; the counter clears.
  - done_rise & ~enable -> IDLE; dac_sample <= 0; grant <= 00.
  - Counter reaching TIMEOUT_CYCLES-1 without done_rise:
    - timeout_err <= 1; the counter clears; the state stays WAIT_DONE.
    - The block keeps waiting; it does not abort.
- enable dropping mid-frame does not truncate the frame. The current word completes, then the block goes IDLE.
- rr_mode changes take effect at the next FETCH.
- Sources must hold valid and data stable until ready. Deasserting valid before ready is legal; that source is simply not selected.
- Latency: done_rise at edge N; FETCH active in cycle N+1; the new dac_sample is visible after edge N+2.
- At most one srcN_ready is high in any cycle. No ready is asserted outside FETCH.
- Any state encoding outside the defined set -> IDLE.

Decomposition:
- Shared package audio_pkg holds:
  - the state enum IDLE/FETCH/WAIT_DONE;
  - AUDIO_DATA_W=32;
  - the default TIMEOUT_CYCLES.
- One natural sub-module, audio_rr_arbiter: 2-input fixed/round-robin selection with a last_grant register and an update strobe. The FSM, timeout counter and underrun counter stay in the top level.

Test Plan:
- Reset mid-WAIT_DONE with underrun_cnt=5 and timeout_err=1 -> all outputs immediately 0; state IDLE.
- Fixed priority:
  - Setup: enable=1, rr_mode=0; src0 and src1 always valid with 0xAAAA0001 / 0x55550002; dac_done pulsed every 40 cycles.
  - Response: every grant=01; dac_sample=0xAAAA0001; src1_ready never high.
- Round robin, same stimulus with rr_mode=1 -> grants alternate 01, 10, 01, ...; the first grant is 01. Exactly one ready pulse per done_rise.
- Underrun:
  - Setup: both valid=0 for 3 frames.
  - UNDERRUN_HOLD=0: dac_sample=0, grant=00, underrun_cnt=3.
  - UNDERRUN_HOLD=1: the last sample 0x12345678 repeats.
- Disable and level-held done:
  - enable dropped 10 cycles into a frame -> dac_sample is held until done_rise, then IDLE with dac_sample=0.
  - dac_done held high for 3 cycles -> only one FETCH.
- Timeout: dac_done never pulsed -> timeout_err=1 at cycle 256 after entering WAIT_DONE. The block stays in WAIT_DONE; the next done_rise still triggers FETCH.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio DAC scheduler and its arbiter.
package audio_pkg;

  localparam int AUDIO_DATA_W         = 32;
  localparam int AUDIO_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    FETCH     = 2'b01,
    WAIT_DONE = 2'b10
  } audio_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_SRC0 = 2'b01;
  localparam logic [1:0] GRANT_SRC1 = 2'b10;

  // Frame counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_rr_arbiter.sv
// Two-input selector: fixed priority (src0 first) or round robin keyed on
// the last source served. The selection is combinational. last_grant moves
// only when the update strobe coincides with a real grant.
import audio_pkg::*;

module audio_rr_arbiter (
  input  logic       AUD_BCLK,
  input  logic       rst,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       rr_mode,
  input  logic       update,
  output logic [1:0] sel
);

  // 0 = src0 was served last, 1 = src1 was served last.
  logic last_grant;

  // Choose a one-hot owner from the current requests.
  always_comb begin
    sel = GRANT_NONE;
    if (valid0 && valid1) begin
      sel = (rr_mode && !last_grant) ? GRANT_SRC1 : GRANT_SRC0;
    end else if (valid0) begin
      sel = GRANT_SRC0;
    end else if (valid1) begin
      sel = GRANT_SRC1;
    end
  end

  // Remember who was served. Reset to src1 so the first round-robin pick is src0.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (update && (sel != GRANT_NONE)) begin
      last_grant <= sel[1];
    end
  end

endmodule

// File: rtl/audio_dac_scheduler.sv
// Feeds one stable word per frame to the DAC serializer. The word comes from
// one of two sources. When neither source has a word, the block sends
// silence or repeats the last word. It also flags a serializer that stops
// reporting done.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | disabled; output word and grant forced to zero
// FETCH     | one cycle; accept a word from the selected source (or underrun)
// WAIT_DONE | hold the word until the serializer's done rises; watch timeout
import audio_pkg::*;

module audio_dac_scheduler #(
  parameter int DATA_W         = AUDIO_DATA_W,
  parameter int TIMEOUT_CYCLES = AUDIO_TIMEOUT_CYCLES,
  parameter int UNDERRUN_HOLD  = 0
) (
  input  logic              AUD_BCLK,
  input  logic              rst,
  input  logic              enable,
  input  logic              rr_mode,
  input  logic              src0_valid,
  input  logic [DATA_W-1:0] src0_data,
  output logic              src0_ready,
  input  logic              src1_valid,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_ready,
  input  logic              dac_done,
  output logic [DATA_W-1:0] dac_sample,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [15:0]       underrun_cnt,
  output logic              timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  audio_state_t  state;
  logic          done_q;
  logic          done_rise;
  logic [CW-1:0] to_cnt;
  logic [1:0]    arb_sel;
  logic          in_fetch;

  assign done_rise = dac_done & ~done_q;
  assign in_fetch  = (state == FETCH);

  // Ready is a decode of the registered state and the live selection.
  // This makes the handshake complete at the FETCH edge.
  assign src0_ready = in_fetch & arb_sel[0];
  assign src1_ready = in_fetch & arb_sel[1];
  assign busy       = (state == FETCH) || (state == WAIT_DONE);

  audio_rr_arbiter u_arb (
    .AUD_BCLK (AUD_BCLK),
    .rst      (rst),
    .valid0   (src0_valid),
    .valid1   (src1_valid),
    .rr_mode  (rr_mode),
    .update   (in_fetch),
    .sel      (arb_sel)
  );

  // Keep the previous done level so that a held done counts as one edge.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= dac_done;
    end
  end

  // Frame sequencer: state, output word, grant, underrun and timeout tracking.
  always_ff @(posedge AUD_BCLK or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      dac_sample   <= '0;
      grant        <= GRANT_NONE;
      underrun_cnt <= 16'd0;
      timeout_err  <= 1'b0;
      to_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          dac_sample <= '0;
          grant      <= GRANT_NONE;
          to_cnt     <= '0;
          if (enable) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          to_cnt <= '0;
          if (arb_sel != GRANT_NONE) begin
            dac_sample <= arb_sel[0] ? src0_data : src1_data;
            grant      <= arb_sel;
          end else begin
            if (UNDERRUN_HOLD == 0) begin
              dac_sample <= '0;
            end
            grant        <= GRANT_NONE;
            underrun_cnt <= sat_inc16(underrun_cnt);
          end
          state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (done_rise) begin
            to_cnt <= '0;
            if (enable) begin
              state <= FETCH;
            end else begin
              state      <= IDLE;
              dac_sample <= '0;
              grant      <= GRANT_NONE;
            end
          end else if (to_cnt == TO_LAST) begin
            // A stalled serializer is flagged. The block keeps waiting so
            // that a late done still restarts the frame cadence.
            timeout_err <= 1'b1;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          dac_sample <= '0;
          grant      <= GRANT_NONE;
          to_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_dac_scheduler.sv
// Self-checking bench for audio_dac_scheduler. Two instances share the same
// stimulus: one outputs silence on underrun and one repeats the last word.
module tb_audio_dac_scheduler;

  logic        AUD_BCLK = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        rr_mode = 1'b0;
  logic        src0_valid = 1'b0;
  logic [31:0] src0_data = '0;
  logic        src1_valid = 1'b0;
  logic [31:0] src1_data = '0;
  logic        dac_done = 1'b0;

  logic        src0_ready, src1_ready, busy, timeout_err;
  logic [31:0] dac_sample;
  logic [1:0]  grant;
  logic [15:0] underrun_cnt;

  logic        h_src0_ready, h_src1_ready, h_busy, h_timeout_err;
  logic [31:0] h_dac_sample;
  logic [1:0]  h_grant;
  logic [15:0] h_underrun_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 AUD_BCLK = ~AUD_BCLK;

  audio_dac_scheduler #(.DATA_W(32), .TIMEOUT_CYCLES(256), .UNDERRUN_HOLD(0)) dut (
    .AUD_BCLK(AUD_BCLK), .rst(rst), .enable(enable), .rr_mode(rr_mode),
    .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
    .dac_done(dac_done), .dac_sample(dac_sample), .grant(grant), .busy(busy),
    .underrun_cnt(underrun_cnt), .timeout_err(timeout_err)
  );

  audio_dac_scheduler #(.DATA_W(32), .TIMEOUT_CYCLES(256), .UNDERRUN_HOLD(1)) dut_h (
    .AUD_BCLK(AUD_BCLK), .rst(rst), .enable(enable), .rr_mode(rr_mode),
    .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(h_src0_ready),
    .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(h_src1_ready),
    .dac_done(dac_done), .dac_sample(h_dac_sample), .grant(h_grant), .busy(h_busy),
    .underrun_cnt(h_underrun_cnt), .timeout_err(h_timeout_err)
  );

  typedef struct {
    logic        v0, v1, rr;
    logic [31:0] d0, d1;
    logic [1:0]  exp_grant;
    logic [31:0] exp_sample;
    logic [31:0] exp_hold;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0; enable = 1'b0; dac_done = 1'b0; rr_mode = 1'b0;
    src0_valid = 1'b0; src1_valid = 1'b0;
    repeat (3) @(posedge AUD_BCLK);
    #1 rst = 1'b1;
    @(posedge AUD_BCLK); #1;
  endtask

  // Present the source inputs and start one frame, either by enabling from
  // IDLE or with a single-cycle done pulse. Then count ready pulses.
  // Call at posedge+1. Returns at posedge+1 while in WAIT_DONE.
  task automatic do_frame(input logic v0, input logic v1, input logic rr,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input int gap, input bit from_idle,
                          output int n_r0, output int n_r1);
    src0_valid = v0; src1_valid = v1; rr_mode = rr;
    src0_data = d0; src1_data = d1;
    if (from_idle) begin
      enable = 1'b1;
    end else begin
      dac_done = 1'b1;
      @(posedge AUD_BCLK); #1;
      dac_done = 1'b0;
    end
    n_r0 = 0; n_r1 = 0;
    repeat (gap) begin
      @(negedge AUD_BCLK);
      if (src0_ready) n_r0++;
      if (src1_ready) n_r1++;
    end
    @(posedge AUD_BCLK); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r0, r1, first, cyc;
    bit held_ok, found;
    logic [31:0] exp_s, exp_h;
    logic [1:0] exp_g;
    int last_src;
    int ucnt;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'hA000_0000, 32'hB000_0000, 2'b01, 32'hA000_0000, 32'hA000_0000};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'hA000_0001, 32'hB000_0001, 2'b10, 32'hB000_0001, 32'hB000_0001};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'hA000_0002, 32'hB000_0002, 2'b01, 32'hA000_0002, 32'hA000_0002};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'hA000_0003, 32'hB000_0003, 2'b10, 32'hB000_0003, 32'hB000_0003};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'hA000_0004, 32'hB000_0004, 2'b01, 32'hA000_0004, 32'hA000_0004};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'hA000_0005, 32'hB000_0005, 2'b00, 32'h0000_0000, 32'hA000_0004};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 32'hA000_0006, 32'hB000_0006, 2'b10, 32'hB000_0006, 32'hB000_0006};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'hA000_0007, 32'hB000_0007, 2'b01, 32'hA000_0007, 32'hA000_0007};

    // Reset values
    #12;
    check("rst_sample", dac_sample, 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'({src0_ready, src1_ready}), 32'h0);
    check("rst_ucnt", 32'(underrun_cnt), 32'h0);
    check("rst_terr", 32'(timeout_err), 32'h0);

    // Table-driven frame sequence
    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_frame(tbl[i].v0, tbl[i].v1, tbl[i].rr, tbl[i].d0, tbl[i].d1, 6, (i == 0), r0, r1);
      check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].exp_grant));
      check($sformatf("tbl%0d_sample", i), dac_sample, tbl[i].exp_sample);
      check($sformatf("tbl%0d_hold", i), h_dac_sample, tbl[i].exp_hold);
      check($sformatf("tbl%0d_r0", i), 32'(r0), 32'(tbl[i].exp_grant == 2'b01));
      check($sformatf("tbl%0d_r1", i), 32'(r1), 32'(tbl[i].exp_grant == 2'b10));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'h1);
    end
    check("tbl_ucnt", 32'(underrun_cnt), 32'd1);

    // Fixed priority with both sources always valid
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_frame(1'b1, 1'b1, 1'b0, 32'hAAAA_0001, 32'h5555_0002, 40, (k == 0), r0, r1);
      check($sformatf("fp%0d_grant", k), 32'(grant), 32'h1);
      check($sformatf("fp%0d_sample", k), dac_sample, 32'hAAAA_0001);
      check($sformatf("fp%0d_r1", k), 32'(r1), 32'h0);
    end

    // Round robin: alternate starting with src0
    do_reset();
    for (int k = 0; k < 6; k++) begin
      do_frame(1'b1, 1'b1, 1'b1, 32'hAAAA_0001, 32'h5555_0002, 40, (k == 0), r0, r1);
      check($sformatf("rr%0d_grant", k), 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr%0d_sample", k), dac_sample, (k % 2 == 0) ? 32'hAAAA_0001 : 32'h5555_0002);
      check($sformatf("rr%0d_readies", k), 32'(r0 + r1), 32'h1);
    end

    // Underrun after one real sample
    do_reset();
    do_frame(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 6, 1'b1, r0, r1);
    for (int k = 0; k < 3; k++) do_frame(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6, 1'b0, r0, r1);
    check("ur_sample", dac_sample, 32'h0);
    check("ur_grant", 32'(grant), 32'h0);
    check("ur_ucnt", 32'(underrun_cnt), 32'd3);
    check("ur_hold_sample", h_dac_sample, 32'h1234_5678);
    check("ur_hold_grant", 32'(h_grant), 32'h0);
    check("ur_hold_ucnt", 32'(h_underrun_cnt), 32'd3);

    // enable dropped mid-frame: the word is held, then the block goes IDLE
    do_reset();
    do_frame(1'b1, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0, 4, 1'b1, r0, r1);
    repeat (5) @(posedge AUD_BCLK);
    #1 enable = 1'b0;
    held_ok = 1'b1; r0 = 0;
    repeat (20) begin
      @(negedge AUD_BCLK);
      if (dac_sample !== 32'hCAFE_0001 || busy !== 1'b1) held_ok = 1'b0;
      if (src0_ready || src1_ready) r0++;
    end
    check("dis_held", 32'(held_ok), 32'h1);
    @(posedge AUD_BCLK); #1 dac_done = 1'b1;
    @(posedge AUD_BCLK); #1 dac_done = 1'b0;
    repeat (4) begin
      @(negedge AUD_BCLK);
      if (src0_ready || src1_ready) r0++;
    end
    check("dis_no_ready", 32'(r0), 32'h0);
    check("dis_busy", 32'(busy), 32'h0);
    check("dis_sample", dac_sample, 32'h0);
    check("dis_grant", 32'(grant), 32'h0);

    // Level-held done counts once
    @(posedge AUD_BCLK); #1;
    do_frame(1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, 32'h0, 6, 1'b1, r0, r1);
    dac_done = 1'b1;
    r0 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge AUD_BCLK);
      if (src0_ready || src1_ready) r0++;
      @(posedge AUD_BCLK); #1;
      if (c == 2) dac_done = 1'b0;
    end
    check("lvl_one_fetch", 32'(r0), 32'h1);

    // Timeout after 256 cycles in WAIT_DONE; the block keeps waiting
    do_reset();
    src0_valid = 1'b1; src0_data = 32'h7777_0001; enable = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge AUD_BCLK);
      if (src0_ready) found = 1'b1;
    end
    check("to_fetch_seen", 32'(found), 32'h1);
    @(posedge AUD_BCLK);
    first = 0;
    for (int k = 1; k <= 300 && first == 0; k++) begin
      @(posedge AUD_BCLK); #1;
      if (timeout_err) first = k;
    end
    check("to_cycle", 32'(first), 32'd256);
    check("to_busy", 32'(busy), 32'h1);
    check("to_sample", dac_sample, 32'h7777_0001);
    do_frame(1'b1, 1'b0, 1'b0, 32'h7777_0002, 32'h0, 6, 1'b0, r0, r1);
    check("to_refetch", 32'(r0), 32'h1);
    check("to_sample2", dac_sample, 32'h7777_0002);
    check("to_sticky", 32'(timeout_err), 32'h1);

    // Asynchronous reset in WAIT_DONE with underrun_cnt=5 and timeout_err=1
    do_reset();
    do_frame(1'b1, 1'b0, 1'b0, 32'hDEAD_0005, 32'h0, 6, 1'b1, r0, r1);
    for (int k = 0; k < 5; k++) do_frame(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6, 1'b0, r0, r1);
    cyc = 0;
    while (!timeout_err && cyc < 400) begin
      @(posedge AUD_BCLK); #1;
      cyc++;
    end
    check("ar_pre_ucnt", 32'(underrun_cnt), 32'd5);
    check("ar_pre_terr", 32'(timeout_err), 32'h1);
    check("ar_pre_hold", h_dac_sample, 32'hDEAD_0005);
    @(negedge AUD_BCLK); #2 rst = 1'b0;
    #1;
    check("ar_sample", h_dac_sample, 32'h0);
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_ucnt", 32'(underrun_cnt), 32'h0);
    check("ar_terr", 32'(timeout_err), 32'h0);
    check("ar_ready", 32'({src0_ready, src1_ready}), 32'h0);

    // Randomized frames against a frame-level reference model
    do_reset();
    last_src = 1;
    ucnt = 0;
    exp_h = 32'h0;
    for (int k = 0; k < 60; k++) begin
      logic v0, v1, rr;
      logic [31:0] d0, d1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      d0 = $urandom;
      d1 = $urandom;
      if (v0 && v1) exp_g = (rr && last_src == 0) ? 2'b10 : 2'b01;
      else if (v0) exp_g = 2'b01;
      else if (v1) exp_g = 2'b10;
      else exp_g = 2'b00;
      if (exp_g == 2'b01) begin exp_s = d0; last_src = 0; end
      else if (exp_g == 2'b10) begin exp_s = d1; last_src = 1; end
      else begin exp_s = 32'h0; ucnt++; end
      if (exp_g != 2'b00) exp_h = exp_s;
      do_frame(v0, v1, rr, d0, d1, $urandom_range(4, 12), (k == 0), r0, r1);
      check($sformatf("rnd%0d_grant", k), 32'(grant), 32'(exp_g));
      check($sformatf("rnd%0d_sample", k), dac_sample, exp_s);
      check($sformatf("rnd%0d_hold", k), h_dac_sample, exp_h);
      check($sformatf("rnd%0d_ready", k), 32'({r1[0], r0[0]}), 32'(exp_g));
      check($sformatf("rnd%0d_ucnt", k), 32'(underrun_cnt), 32'(ucnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
